// File: rtl/prog_loader_pkg.sv
// prog_loader shared types: FSM state enum, output bundle, width defaults.
// PROG_LOADER_CHECKSUM_EN adds the CHECK state.
package prog_loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHECK   = 3'd2,
`endif
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    typedef struct packed {
        logic byte_ready;
        logic cpu_reset;
        logic cpu_run;
        logic busy;
        logic done;
        logic error;
    } ctrl_t;

    function automatic ctrl_t decode(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_IDLE: c.cpu_reset = 1'b1;
            S_LOAD: begin
                c.byte_ready = 1'b1;
                c.cpu_reset  = 1'b1;
                c.busy       = 1'b1;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHECK: begin
                c.byte_ready = 1'b1;
                c.cpu_reset  = 1'b1;
                c.busy       = 1'b1;
            end
`endif
            S_RELEASE: begin
                c.cpu_reset = 1'b1;
                c.busy      = 1'b1;
            end
            S_RUN: begin
                c.cpu_run = 1'b1;
                c.done    = 1'b1;
            end
            S_ERROR: begin
                c.cpu_reset = 1'b1;
                c.error     = 1'b1;
            end
            default: c.cpu_reset = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/prog_loader_release.sv
// release_timer: loadable down-counter holding the CPU in reset.
// zero flags the final cycle of the release window.
module release_timer #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] cnt;

    // Load CYCLES-1 on entry so the window spans exactly CYCLES cycles
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= W'(CYCLES - 1);
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams program bytes into imem, then releases the CPU.
// PROG_LOADER_CHECKSUM_EN enables a trailing checksum byte check.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_LEN      = 256,
    parameter int RESET_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              imem_write,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_data,
    output logic              cpu_reset,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   count
);

    state_t            state;
    state_t            nx;
    ctrl_t             ctrl;
    logic [ADDR_W-1:0] ptr;
    logic              acc;
    logic              tmr_zero;
    logic              restart;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        sum;
    logic [7:0]        chk;
`endif

    assign acc = byte_valid & byte_ready;

    // start restarts from anywhere except while bytes are flowing
    assign restart = start && state != S_LOAD
`ifdef PROG_LOADER_CHECKSUM_EN
                     && state != S_CHECK
`endif
                     ;

`ifdef PROG_LOADER_CHECKSUM_EN
    assign chk = sum + 8'(byte_data);
`endif

    // Next-state selection
    always_comb begin
        nx = state;
        if (restart) begin
            nx = S_LOAD;
        end else begin
            case (state)
                S_LOAD: begin
                    if (acc && (byte_last ||
                        ptr == ADDR_W'(MAX_LEN - 1)))
`ifdef PROG_LOADER_CHECKSUM_EN
                        nx = S_CHECK;
`else
                        nx = S_RELEASE;
`endif
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CHECK:
                    if (acc)
                        nx = (chk == 8'h00) ? S_RELEASE : S_ERROR;
`endif
                S_RELEASE:
                    if (tmr_zero)
                        nx = S_RUN;
                S_RUN:
                    if (stop)
                        nx = S_IDLE;
                default: nx = state;
            endcase
        end
    end

    // State register with outputs registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            ctrl  <= decode(S_IDLE);
        end else begin
            state <= nx;
            ctrl  <= decode(nx);
        end
    end

    // Write pointer, byte count and registered imem write port
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            count      <= '0;
            imem_write <= 1'b0;
            imem_addr  <= '0;
            imem_data  <= '0;
        end else begin
            imem_write <= 1'b0;
            if (restart) begin
                ptr   <= '0;
                count <= '0;
            end else if (acc && state == S_LOAD) begin
                imem_write <= 1'b1;
                imem_addr  <= ptr;
                imem_data  <= byte_data;
                ptr        <= ptr + 1'b1;
                count      <= count + 1'b1;
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running sum of data bytes, compared against the checksum byte
    always_ff @(posedge clk) begin
        if (reset || restart)
            sum <= '0;
        else if (acc && state == S_LOAD)
            sum <= chk;
    end
`endif

    release_timer #(
        .CYCLES (RESET_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (nx == S_RELEASE && state != S_RELEASE),
        .en    (state == S_RELEASE),
        .zero  (tmr_zero)
    );

    assign byte_ready = ctrl.byte_ready;
    assign cpu_reset  = ctrl.cpu_reset;
    assign cpu_run    = ctrl.cpu_run;
    assign busy       = ctrl.busy;
    assign done       = ctrl.done;
    assign error      = ctrl.error;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; checksum steps run when
// PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_last = 1'b0;
    logic       byte_ready;
    logic       imem_write;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       cpu_reset;
    logic       cpu_run;
    logic       busy;
    logic       done;
    logic       error;
    logic [8:0] count;

    int tests = 0;
    int fails = 0;

    prog_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .imem_write (imem_write),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .cpu_reset  (cpu_reset),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = l;
        tick();
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_cpu_run", cpu_run, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_ready", byte_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_write", imem_write, 0);

        // Three-byte load
        pulse_start();
        chk("load_ready", byte_ready, 1);
        chk("load_busy", busy, 1);
        send(8'h11, 1'b0);
        chk("w0_we", imem_write, 1);
        chk("w0_addr", imem_addr, 8'h00);
        chk("w0_data", imem_data, 8'h11);
        send(8'h22, 1'b0);
        chk("w1_addr", imem_addr, 8'h01);
        chk("w1_data", imem_data, 8'h22);
        send(8'h33, 1'b1);
        // now cycle T+1 after the last handshake
        chk("w2_addr", imem_addr, 8'h02);
        chk("w2_data", imem_data, 8'h33);
        chk("w2_count", count, 3);
        chk("rel_ready", byte_ready, 0);
        chk("rel_busy", busy, 1);
        chk("rel_cpu_reset", cpu_reset, 1);
        tick();
        chk("rel_nowrite", imem_write, 0);
        chk("rel_addr_hold", imem_addr, 8'h02);
        tick();
        tick();
        chk("rel_t4_reset", cpu_reset, 1);
        chk("rel_t4_run", cpu_run, 0);
        tick();
        chk("run_cpu_reset", cpu_reset, 0);
        chk("run_cpu_run", cpu_run, 1);
        chk("run_done", done, 1);
        chk("run_busy", busy, 0);

        // Stop pulse returns to IDLE
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_cpu_reset", cpu_reset, 1);
        chk("stop_cpu_run", cpu_run, 0);
        chk("stop_done", done, 0);
        chk("stop_busy", busy, 0);

        // Bytes offered in IDLE are ignored
        send(8'h55, 1'b0);
        chk("idle_nowrite", imem_write, 0);
        chk("idle_count", count, 3);

        // Fresh load with byte_valid toggling
        pulse_start();
        chk("fresh_count", count, 0);
        for (int i = 0; i < 4; i++) begin
            send(8'hA0 + 8'(i), i == 3);
            chk("tog_we", imem_write, 1);
            chk("tog_addr", imem_addr, 32'(i));
            chk("tog_data", imem_data, 32'hA0 + 32'(i));
            tick();
            chk("tog_gap", imem_write, 0);
        end
        chk("tog_count", count, 4);
        tick();
        tick();
        chk("tog_t4_reset", cpu_reset, 1);
        tick();
        chk("tog_run", cpu_run, 1);
        chk("tog_reset_low", cpu_reset, 0);

        // Start from RUN; 256 bytes with implicit last
        pulse_start();
        chk("full_ready", byte_ready, 1);
        chk("full_reset", cpu_reset, 1);
        for (int i = 0; i < 256; i++) begin
            send(8'(i ^ 8'h5A), 1'b0);
            chk("full_addr", imem_addr, 32'(i));
        end
        chk("full_data", imem_data, 32'hFF ^ 32'h5A);
        chk("full_count", count, 256);
        chk("full_ready_off", byte_ready, 0);
        chk("full_busy", busy, 1);
        tick();
        tick();
        tick();
        chk("full_t4_reset", cpu_reset, 1);
        tick();
        chk("full_done", done, 1);

        // start is ignored while loading
        pulse_start();
        send(8'h01, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_ready", byte_ready, 1);
        send(8'h02, 1'b0);
        chk("ign_addr", imem_addr, 8'h01);
        chk("ign_count", count, 2);

        // Synchronous reset mid-load
        byte_valid = 1'b1;
        byte_data  = 8'h77;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
        byte_valid = 1'b0;
        chk("mid_cpu_reset", cpu_reset, 1);
        chk("mid_count", count, 0);
        chk("mid_ready", byte_ready, 0);
        chk("mid_busy", busy, 0);
        chk("mid_write", imem_write, 0);
        chk("mid_done", done, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Good checksum
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h02, 1'b1);
        chk("cs_check_ready", byte_ready, 1);
        send(8'hFD, 1'b0);
        chk("cs_nowrite", imem_write, 0);
        chk("cs_count", count, 2);
        chk("cs_rel_ready", byte_ready, 0);
        tick();
        tick();
        tick();
        chk("cs_t4_reset", cpu_reset, 1);
        tick();
        chk("cs_run", cpu_run, 1);
        chk("cs_error", error, 0);

        // Bad checksum
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h02, 1'b1);
        send(8'hFC, 1'b0);
        chk("bad_error", error, 1);
        chk("bad_cpu_reset", cpu_reset, 1);
        chk("bad_ready", byte_ready, 0);
        tick();
        tick();
        chk("bad_sticky", error, 1);
        pulse_start();
        chk("bad_cleared", error, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
